// File: rtl/extender_pkg.sv
// Shared widths, format-select encoding and field-LSB positions for the
// decode-stage immediate extender.
package extender_pkg;

    localparam int IN_W  = 27;
    localparam int OUT_W = 32;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_19   = 2'd1,
        SEL_23   = 2'd2,
        SEL_27   = 2'd3
    } sel_e;

    localparam int LSB_19 = 8;
    localparam int LSB_23 = 4;
    localparam int LSB_27 = 0;

endpackage

// File: rtl/extender_comb.sv
// Combinational field select and extension of the instruction immediate.
// Build option EXTENDER_SIGN_EXT_EN switches zero-extension to sign-extension.
module extender_comb
    import extender_pkg::*;
(
    input  logic [IN_W-1:0]  inmeIn,
    input  logic [1:0]       sel,
    output logic [OUT_W-1:0] inmeExt
);

    // Every field ends at bit IN_W-1, so the raw region is parked at the top of
    // the operand and shifted down; the shift type sets the fill bits.
    function automatic logic [OUT_W-1:0] extendField(input logic [IN_W-1:0] raw,
                                                     input int unsigned lsb);
        logic signed [OUT_W-1:0] aligned;
        aligned = {raw, {(OUT_W-IN_W){1'b0}}};
`ifdef EXTENDER_SIGN_EXT_EN
        return aligned >>> (lsb + OUT_W - IN_W);
`else
        return aligned >> (lsb + OUT_W - IN_W);
`endif
    endfunction

    always_comb begin
        inmeExt = '0;
        case (sel_e'(sel))
            SEL_19:  inmeExt = extendField(inmeIn, LSB_19);
            SEL_23:  inmeExt = extendField(inmeIn, LSB_23);
            SEL_27:  inmeExt = extendField(inmeIn, LSB_27);
            default: inmeExt = '0;
        endcase
    end

endmodule

// File: rtl/extender.sv
// Decode-stage immediate extender: field select/extend plus one output register.
// Build option EXTENDER_SIGN_EXT_EN selects sign-extension (see extender_comb).
module extender
    import extender_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  inmeIn,
    input  logic [1:0]       Sel,
    output logic [OUT_W-1:0] inmeOut
);

    logic [OUT_W-1:0] inmeExt;

    extender_comb uComb (
        .inmeIn  (inmeIn),
        .sel     (Sel),
        .inmeExt (inmeExt)
    );

    // Output register: reset wins over capture, en low holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            inmeOut <= '0;
        end else if (en) begin
            inmeOut <= inmeExt;
        end
    end

endmodule

// File: tb/tb_extender.sv
// Scoreboarded bench for extender: directed boundary steps plus randomized
// traffic against a field-width arithmetic reference model.
module tb_extender;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [26:0] inmeIn;
    logic [1:0]  Sel;
    logic [31:0] inmeOut;

    int checks = 0;
    int errors = 0;

    logic [31:0] expQ[$];
    string       nameQ[$];
    logic [31:0] mdlOut = 32'd0;

    localparam logic [26:0] ONES = 27'h7FFFFFF;

    extender dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .inmeIn  (inmeIn),
        .Sel     (Sel),
        .inmeOut (inmeOut)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] refExt(input logic [26:0] v, input logic [1:0] s);
        int w;
        longint unsigned f;
        if (s == 2'd0) return 32'd0;
        w = (s == 2'd1) ? 19 : (s == 2'd2) ? 23 : 27;
        f = longint'(v) >> (27 - w);
`ifdef EXTENDER_SIGN_EXT_EN
        if (v[26]) f = f | (~64'd0 << w);
`endif
        return f[31:0];
    endfunction

    // Applies one cycle of inputs; expected register value after the next edge.
    task automatic drive(input logic r, input logic e, input logic [26:0] v,
                         input logic [1:0] s, input logic useExp,
                         input logic [31:0] exp, input string name);
        rst = r; en = e; inmeIn = v; Sel = s;
        if (useExp)      mdlOut = exp;
        else if (r)      mdlOut = 32'd0;
        else if (e)      mdlOut = refExt(v, s);
        expQ.push_back(mdlOut);
        nameQ.push_back(name);
        @(negedge clk);
    endtask

    // Monitor: one registered result per clock edge.
    initial begin
        logic [31:0] exp;
        string       name;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                exp  = expQ.pop_front();
                name = nameQ.pop_front();
                checks++;
                if (inmeOut !== exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", name, inmeOut, exp);
                end
            end
        end
    end

    initial begin
        logic [31:0] allOnes1, allOnes2, allOnes3, msb1, msb2, msb3;
`ifdef EXTENDER_SIGN_EXT_EN
        allOnes1 = 32'hFFFFFFFF; allOnes2 = 32'hFFFFFFFF; allOnes3 = 32'hFFFFFFFF;
        msb1 = 32'hFFFC0000; msb2 = 32'hFFC00000; msb3 = 32'hFC000000;
`else
        allOnes1 = 32'h0007FFFF; allOnes2 = 32'h007FFFFF; allOnes3 = 32'h07FFFFFF;
        msb1 = 32'h00040000; msb2 = 32'h00400000; msb3 = 32'h04000000;
`endif
        drive(1, 1, ONES, 2'd3, 1, 32'd0, "reset0");
        drive(1, 1, ONES, 2'd3, 1, 32'd0, "reset1");
        drive(0, 1, ONES, 2'd3, 1, allOnes3, "releaseOnes");
        drive(0, 1, 27'h100, 2'd1, 1, 32'd1, "sel1Bit8");
        drive(0, 1, 27'h080, 2'd1, 1, 32'd0, "sel1Bit7");
        drive(0, 1, 27'h010, 2'd2, 1, 32'd1, "sel2Bit4");
        drive(0, 1, 27'h008, 2'd2, 1, 32'd0, "sel2Bit3");
        drive(0, 1, 27'h001, 2'd3, 1, 32'd1, "sel3Bit0");
        drive(0, 1, ONES, 2'd0, 1, 32'd0, "sel0Ones");
        drive(0, 1, ONES, 2'd1, 1, allOnes1, "ones1");
        drive(0, 1, ONES, 2'd2, 1, allOnes2, "ones2");
        drive(0, 1, ONES, 2'd3, 1, allOnes3, "ones3");
        drive(0, 1, 27'h4000000, 2'd1, 1, msb1, "msb1");
        drive(0, 1, 27'h4000000, 2'd2, 1, msb2, "msb2");
        drive(0, 1, 27'h4000000, 2'd3, 1, msb3, "msb3");
        drive(0, 1, 27'h0, 2'd1, 1, 32'd0, "zeros1");
        drive(0, 1, 27'h0, 2'd2, 1, 32'd0, "zeros2");
        drive(0, 1, 27'h0, 2'd3, 1, 32'd0, "zeros3");
        drive(0, 1, 27'h001, 2'd3, 1, 32'd1, "holdLoad");
        drive(0, 0, ONES, 2'd1, 1, 32'd1, "holdA");
        drive(0, 0, 27'h5A5A5A5, 2'd2, 1, 32'd1, "holdB");
        drive(1, 0, ONES, 2'd3, 1, 32'd0, "rstNoEn");
        drive(0, 1, ONES, 2'd3, 1, allOnes3, "reload");
        drive(1, 1, ONES, 2'd2, 1, 32'd0, "rstOverEn");

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  27'($urandom), 2'($urandom_range(0, 3)), 0, 32'd0, "random");
        end

        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results pending, expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
